// File: rtl/chunked_adder.sv
// Multi-cycle adder: sums WIDTH-bit operands CHUNK bits per cycle with valid/ready handshakes.
// Optional subtract mode (port sub) is enabled by defining CHUNKED_ADDER_SUB_EN.
module chunked_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
`ifdef CHUNKED_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SafeChunk = (CHUNK == 0) ? 1 : CHUNK;
  localparam int unsigned N         = WIDTH / SafeChunk;
  localparam int unsigned KW        = (N > 1) ? $clog2(N) : 1;

  if ((CHUNK < 1) || ((WIDTH % SafeChunk) != 0)) begin : g_bad_params
    $error("chunked_adder: CHUNK must be >= 1 and divide WIDTH");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e             r_state;
  state_e             w_state_next;
  logic [WIDTH-1:0]   r_x;
  logic [WIDTH-1:0]   r_y;
  logic               r_carry;
  logic [KW-1:0]      r_k;
  logic [WIDTH-1:0]   r_s;
  logic               r_cout;
  logic               r_ovf;

  logic [CHUNK-1:0]   w_a;
  logic [CHUNK-1:0]   w_b;
  logic [CHUNK:0]     w_sum;
  logic               w_last;
  logic               w_c_msb;
  logic [WIDTH-1:0]   w_y_eff;
  logic               w_cin_eff;

`ifdef CHUNKED_ADDER_SUB_EN
  // Subtraction folds into addition: x + ~y + ~cin.
  assign w_y_eff   = sub ? ~y : y;
  assign w_cin_eff = cin ^ sub;
`else
  assign w_y_eff   = y;
  assign w_cin_eff = cin;
`endif

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < N; i++) begin
      if (r_k == KW'(i)) begin
        w_a = r_x[i*CHUNK +: CHUNK];
        w_b = r_y[i*CHUNK +: CHUNK];
      end
    end
  end

  assign w_sum   = {1'b0, w_a} + {1'b0, w_b} + {{CHUNK{1'b0}}, r_carry};
  assign w_last  = (r_k == KW'(N - 1));
  // Carry into the chunk MSB recovered from the sum bit and its two addend bits.
  assign w_c_msb = w_a[CHUNK-1] ^ w_b[CHUNK-1] ^ w_sum[CHUNK-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (in_valid)  w_state_next = StBusy;
      StBusy:  if (w_last)    w_state_next = StDone;
      StDone:  if (out_ready) w_state_next = StIdle;
      default:                w_state_next = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == StIdle) && !rst;
    out_valid = (r_state == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x     <= '0;
      r_y     <= '0;
      r_carry <= 1'b0;
      r_k     <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_x     <= x;
            r_y     <= w_y_eff;
            r_carry <= w_cin_eff;
            r_k     <= '0;
          end
        end
        StBusy: begin
          for (int i = 0; i < N; i++) begin
            if (r_k == KW'(i)) begin
              r_s[i*CHUNK +: CHUNK] <= w_sum[CHUNK-1:0];
            end
          end
          r_carry <= w_sum[CHUNK];
          r_k     <= r_k + 1'b1;
          if (w_last) begin
            r_cout <= w_sum[CHUNK];
            r_ovf  <= w_c_msb ^ w_sum[CHUNK];
          end
        end
        default: ;
      endcase
    end
  end

  assign s    = r_s;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_chunked_adder.sv
// Scoreboard bench for chunked_adder: 16/4 instance plus an 8/8 single-cycle instance.
// Subtract vectors run only when CHUNKED_ADDER_SUB_EN is defined.
module tb_chunked_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] x, y, s;
  logic        in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8;
  logic [7:0]  x8, y8, s8;

  chunked_adder #(.WIDTH(16), .CHUNK(4)) u_dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .cin       (cin),
`ifdef CHUNKED_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf)
  );

  chunked_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .x         (x8),
    .y         (y8),
    .cin       (cin8),
`ifdef CHUNKED_ADDER_SUB_EN
    .sub       (sub8),
`endif
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .s         (s8),
    .cout      (cout8),
    .ovf       (ovf8)
  );

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    int          t;
  } exp16_t;

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       o;
    int         t;
  } exp8_t;

  exp16_t q16[$];
  exp8_t  q8[$];
  int     cyc = 0;
  int     n_cmp = 0;
  int     n_err = 0;
  logic   prev16 = 1'b0;
  logic   prev8 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: condition not met (cycle %0d)", name, cyc);
  endtask

  // Monitor for the 16-bit instance: latency on the rising edge, values every valid cycle.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q16.size() == 0) begin
        fail("unexpected_out16");
      end else begin
        if (!prev16) chk("latency16", cyc - q16[0].t, 4);
        chk("s16", {16'h0, s}, {16'h0, q16[0].s});
        chk("cout16", {31'h0, cout}, {31'h0, q16[0].c});
        chk("ovf16", {31'h0, ovf}, {31'h0, q16[0].o});
        chk("in_ready_done16", {31'h0, in_ready}, 32'h0);
        if (out_ready) void'(q16.pop_front());
      end
    end
    prev16 <= out_valid;
  end

  always @(negedge clk) begin
    if (!rst && out_valid8) begin
      if (q8.size() == 0) begin
        fail("unexpected_out8");
      end else begin
        if (!prev8) chk("latency8", cyc - q8[0].t, 1);
        chk("s8", {24'h0, s8}, {24'h0, q8[0].s});
        chk("cout8", {31'h0, cout8}, {31'h0, q8[0].c});
        chk("ovf8", {31'h0, ovf8}, {31'h0, q8[0].o});
        if (out_ready8) void'(q8.pop_front());
      end
    end
    prev8 <= out_valid8;
  end

  // Issues one operand set; ng extra edges of garbage with in_valid held high follow the accept.
  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic sb, input bit push, input int ng,
                        input logic [15:0] es, input logic ec, input logic eo);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      fail("in_ready_timeout16");
      return;
    end
    x = a; y = b; cin = c; sub = sb; in_valid = 1'b1;
    @(posedge clk);
    #1;
    if (push) q16.push_back('{s: es, c: ec, o: eo, t: cyc});
    x = ~a; y = ~b; cin = ~c; sub = ~sb;
    repeat (ng) @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [7:0] es, input logic ec, input logic eo);
    int n = 0;
    @(negedge clk);
    while (!in_ready8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready8) begin
      fail("in_ready_timeout8");
      return;
    end
    x8 = a; y8 = b; cin8 = c; in_valid8 = 1'b1;
    @(posedge clk);
    #1;
    q8.push_back('{s: es, c: ec, o: eo, t: cyc});
    x8 = ~a; y8 = ~b; cin8 = ~c;
    in_valid8 = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((q16.size() != 0 || q8.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q16.size() != 0 || q8.size() != 0) fail(name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0; x = '0; y = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0; x8 = '0; y8 = '0; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;
    repeat (3) @(negedge clk);
    chk("in_ready_in_rst", {31'h0, in_ready}, 32'h0);
    rst = 1'b0;
    #1;
    chk("rst_s", {16'h0, s}, 32'h0);
    chk("rst_cout", {31'h0, cout}, 32'h0);
    chk("rst_ovf", {31'h0, ovf}, 32'h0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);

    send16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 2, 16'h0000, 1'b1, 1'b0);
    send16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 2, 16'h8000, 1'b0, 1'b1);
    send16(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 0, 16'h0001, 1'b0, 1'b0);
    send16(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, 2, 16'h0000, 1'b1, 1'b1);
    send16(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 1'b1, 2, 16'h0000, 1'b1, 1'b0);
    send16(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b1, 3, 16'h0007, 1'b0, 1'b0);
    drain("drain_basic");

    // Consumer stalls for three cycles; the monitor re-checks the held result each cycle.
    out_ready = 1'b0;
    send16(16'h1234, 16'h4321, 1'b1, 1'b0, 1'b1, 2, 16'h5556, 1'b0, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) fail("hold_wait_valid");
    repeat (3) @(negedge clk);
    chk("hold_out_valid", {31'h0, out_valid}, 32'h1);
    chk("hold_in_ready", {31'h0, in_ready}, 32'h0);
    out_ready = 1'b1;
    drain("drain_hold");

    // Reset during the second busy cycle discards the transaction.
    send16(16'hAAAA, 16'h5555, 1'b1, 1'b0, 1'b0, 0, 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_out_valid", {31'h0, out_valid}, 32'h0);
    chk("abort_s", {16'h0, s}, 32'h0);
    chk("abort_cout", {31'h0, cout}, 32'h0);
    chk("abort_in_ready", {31'h0, in_ready}, 32'h1);
    repeat (6) @(negedge clk);
    send16(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, 2, 16'h3333, 1'b0, 1'b0);
    drain("drain_abort");

`ifdef CHUNKED_ADDER_SUB_EN
    send16(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, 2, 16'hFFFE, 1'b0, 1'b0);
    send16(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b1, 2, 16'h0002, 1'b1, 1'b0);
    send16(16'h0007, 16'h0005, 1'b1, 1'b1, 1'b1, 2, 16'h0001, 1'b1, 1'b0);
    drain("drain_sub");
`endif

    send8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    send8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    send8(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);
    send8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    drain("drain_8");

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/chunked_adder.md
CHUNKED_ADDER -- requirements
Module: chunked_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand/sum width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, meaning bits added per cycle; WIDTH % CHUNK == 0 and CHUNK >= 1 are required, otherwise elaboration fails.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  operands present.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port x  input  WIDTH  operand A.
REQ-008 SHALL have port y  input  WIDTH  operand B.
REQ-009 SHALL have port cin  input  1  carry-in.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port s  output  WIDTH  sum.
REQ-013 SHALL have port cout  output  1  carry out of MSB.
REQ-014 SHALL have port ovf  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB).

Function
REQ-015 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-016 SHALL drive in_ready = 1 only in IDLE with rst low; in_ready SHALL be 0 in BUSY and DONE.
REQ-017 SHALL accept operands on an edge where in_valid && in_ready: latch x, y and cin, clear the chunk index k, enter BUSY.
REQ-018 SHALL, in BUSY, add chunk k (bits k*CHUNK+CHUNK-1 : k*CHUNK) plus the running carry each cycle, store the chunk sum into s, register the new carry and increment k.
REQ-019 SHALL leave BUSY after N = WIDTH/CHUNK cycles: accept at edge T, out_valid = 1 from edge T+N, state DONE.
REQ-020 SHALL capture cout and ovf on the last chunk; ovf uses the carry into bit WIDTH-1 as computed within the last chunk.
REQ-021 SHALL hold s, cout, ovf and out_valid stable in DONE until out_ready = 1; on that edge it SHALL clear out_valid and enter IDLE (one idle cycle minimum between results; no overlapped accept).
REQ-022 SHALL ignore x, y, cin and in_valid outside IDLE; operands changing during BUSY SHALL not affect the result.
REQ-023 SHALL produce s = (x + y + cin) mod 2^WIDTH for all inputs; cout = bit WIDTH of the full sum.
REQ-024 SHALL treat CHUNK == WIDTH as a single-cycle add (N = 1).
REQ-025 SHALL leave s/cout/ovf at their last values in IDLE; their values are valid only while out_valid = 1.

Reset
REQ-026 SHALL, with rst high at an edge, force state IDLE, k = 0, s = 0, cout = 0, ovf = 0, out_valid = 0, internal carry = 0.
REQ-027 SHALL abort any BUSY or DONE transaction on reset with no result delivered; rst has priority over every other event.
REQ-028 SHALL assert in_ready in the first cycle after rst falls.

Configuration
REQ-029 SHALL, with macro CHUNKED_ADDER_SUB_EN defined, add port sub (input, 1), latched at accept; sub = 1 computes x + ~y + (cin ^ 1), i.e. x - y - cin, with cout = 1 meaning no borrow.
REQ-030 SHALL, without CHUNKED_ADDER_SUB_EN, have no sub port and perform addition only.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-031 SHALL check x=0xFFFF, y=0x0001, cin=0 -> s=0x0000, cout=1, ovf=0, out_valid exactly 4 edges after accept.
REQ-032 SHALL check x=0x7FFF, y=0x0001, cin=0 -> s=0x8000, cout=0, ovf=1.
REQ-033 SHALL check x=0x1234, y=0x4321, cin=1, out_ready held 0 for 3 cycles -> s=0x5556 held stable, in_ready=0, out_valid=1 until out_ready rises.
REQ-034 SHALL check rst pulsed during the 2nd BUSY cycle -> out_valid never asserts, s=0, in_ready=1 the cycle after rst falls; next transaction correct.
REQ-035 SHALL check, with CHUNKED_ADDER_SUB_EN, x=0x0005, y=0x0007, sub=1, cin=0 -> s=0xFFFE, cout=0.
REQ-036 SHALL check WIDTH=8, CHUNK=8: x=0x80, y=0x80, cin=0 -> s=0x00, cout=1, ovf=1, out_valid 1 edge after accept.
